// File: rtl/watchdog_timer_unit.sv
// Supervisory watchdog: 32-bit up-counter restarted by heartbeats. It warns near
// expiry and latches a sticky trip flag on expiry or on a forced request.
module watchdog_timer_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned WARN_CYCLES    = 40_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        heartbeat,
  input  logic        force_reset,
  output logic [31:0] counter,
  output logic [31:0] time_left,
  output logic        warning,
  output logic        triggered
);

  localparam int unsigned CW = 32;
  localparam logic [CW-1:0] TIMEOUT   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WARN      = CW'(WARN_CYCLES);
  localparam logic [CW-1:0] LAST_TICK = TIMEOUT - CW'(1);

  logic [CW-1:0] counter_next;
  logic [CW-1:0] counter_inc;
  logic          warning_next;
  logic          triggered_next;

  assign counter_inc = counter + CW'(1);

  // Priority-ordered update: force, disable, tripped hold, kick, expiry, count.
  always_comb begin
    counter_next   = counter;
    warning_next   = warning;
    triggered_next = triggered;
    if (force_reset) begin
      triggered_next = 1'b1;
      warning_next   = 1'b0;
    end else if (!enable) begin
      counter_next = '0;
      warning_next = 1'b0;
    end else if (triggered) begin
      counter_next   = counter;
      warning_next   = warning;
      triggered_next = 1'b1;
    end else if (heartbeat) begin
      counter_next = '0;
      warning_next = 1'b0;
    end else if (counter == LAST_TICK) begin
      counter_next   = TIMEOUT;
      triggered_next = 1'b1;
      warning_next   = 1'b0;
    end else begin
      counter_next = counter_inc;
      warning_next = (counter_inc >= WARN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      warning   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      counter   <= counter_next;
      warning   <= warning_next;
      triggered <= triggered_next;
    end
  end

  // Counter saturates at TIMEOUT, so this cannot underflow.
  assign time_left = TIMEOUT - counter;

endmodule

// File: tb/tb_watchdog_timer_unit.sv
// Directed self-checking bench for watchdog_timer_unit with TIMEOUT=16, WARN=12.
module tb_watchdog_timer_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        heartbeat;
  logic        force_reset;
  logic [31:0] counter;
  logic [31:0] time_left;
  logic        warning;
  logic        triggered;

  int total = 0;
  int bad   = 0;

  watchdog_timer_unit #(
    .TIMEOUT_CYCLES(16),
    .WARN_CYCLES   (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .heartbeat  (heartbeat),
    .force_reset(force_reset),
    .counter    (counter),
    .time_left  (time_left),
    .warning    (warning),
    .triggered  (triggered)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full state check: counter, derived time_left, warning and triggered.
  task automatic check_all(input string tag, input int cnt, input logic warn, input logic trig);
    check({tag, ".counter"},   counter,   32'(cnt));
    check({tag, ".time_left"}, time_left, 32'(16 - cnt));
    check({tag, ".warning"},   {31'd0, warning},   {31'd0, warn});
    check({tag, ".triggered"}, {31'd0, triggered}, {31'd0, trig});
  endtask

  task automatic sync_reset;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; heartbeat = 1'b0; force_reset = 1'b0;
    tick(2);
    check_all("reset", 0, 1'b0, 1'b0);

    // 1. async reset mid-count, without a clock edge
    rst = 1'b0; enable = 1'b1;
    tick(7);
    check_all("pre_async", 7, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 check_all("async_rst", 0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;

    // 2. free-running to expiry, then frozen
    tick(11);
    check_all("cnt11", 11, 1'b0, 1'b0);
    tick(1);
    check_all("warn12", 12, 1'b1, 1'b0);
    tick(3);
    check_all("cnt15", 15, 1'b1, 1'b0);
    tick(1);
    check_all("expire16", 16, 1'b0, 1'b1);
    tick(5);
    check_all("frozen", 16, 1'b0, 1'b1);

    // 3. heartbeat restarts the count; regular kicks prevent a trip
    sync_reset();
    tick(10);
    check_all("cnt10", 10, 1'b0, 1'b0);
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    check_all("kick10", 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      tick(14);
      check_all("kick_loop_pre", 14, 1'b1, 1'b0);
      heartbeat = 1'b1;
      tick(1);
      heartbeat = 1'b0;
      check_all("kick_loop_post", 0, 1'b0, 1'b0);
    end

    // 4. force trip while disabled; heartbeat cannot clear it
    sync_reset();
    enable = 1'b0; force_reset = 1'b1;
    tick(1);
    force_reset = 1'b0;
    check_all("force", 0, 1'b0, 1'b1);
    enable = 1'b1; heartbeat = 1'b1;
    tick(3);
    heartbeat = 1'b0;
    check_all("force_hb", 0, 1'b0, 1'b1);

    // 5. enable drop restarts from zero
    sync_reset();
    enable = 1'b1;
    tick(5);
    check_all("cnt5", 5, 1'b0, 1'b0);
    enable = 1'b0;
    tick(1);
    check_all("disabled", 0, 1'b0, 1'b0);
    enable = 1'b1;
    tick(1);
    check_all("reen1", 1, 1'b0, 1'b0);
    tick(1);
    check_all("reen2", 2, 1'b0, 1'b0);
    tick(13);
    check_all("reen15", 15, 1'b1, 1'b0);
    tick(1);
    check_all("reen16", 16, 1'b0, 1'b1);

    // 6. heartbeat on the expiry edge wins; later trip cleared by async reset
    sync_reset();
    tick(15);
    check_all("edge15", 15, 1'b1, 1'b0);
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    check_all("edge_kick", 0, 1'b0, 1'b0);
    tick(16);
    check_all("later_trip", 16, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1 check_all("rst_trip", 0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
